// File: rtl/crack_scheduler.sv
// Round-robin chunk dispatcher for parallel ARC4 crack engines; stops dispatching on the first hit and drains.
// Optional build macro CRACK_SCHED_ABORT_EN adds core_abort to cut the drain short.
module crack_scheduler #(
  parameter int NUM_CORES  = 2,
  parameter int CHUNK_LOG2 = 20,
  parameter int KEY_W      = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  output logic                         rdy,
  output logic [KEY_W-1:0]             key,
  output logic                         key_valid,
  output logic [NUM_CORES-1:0]         core_en,
  input  logic [NUM_CORES-1:0]         core_rdy,
  output logic [NUM_CORES*KEY_W-1:0]   core_start_key,
  output logic [NUM_CORES*KEY_W-1:0]   core_end_key,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*KEY_W-1:0]   core_key
`ifdef CRACK_SCHED_ABORT_EN
  ,
  output logic [NUM_CORES-1:0]         core_abort
`endif
);

  localparam int unsigned NC    = NUM_CORES;
  localparam int          PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [KEY_W:0]   CHUNK   = {{KEY_W{1'b0}}, 1'b1} << CHUNK_LOG2;
  localparam logic [KEY_W:0]   KEY_MAX = {1'b0, {KEY_W{1'b1}}};
  localparam logic [KEY_W+1:0] ONE     = {{(KEY_W+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_next;

  logic [NUM_CORES-1:0] busy, seen_low, complete, remaining, eligible, disp_sel;
  logic [KEY_W:0]       next_key;
  logic [PTR_W-1:0]     rr_ptr, ptr_next;
  logic                 hit_any, disp_any, disp_ok;
  logic [KEY_W-1:0]     hit_key, end_key;
  logic [KEY_W+1:0]     end_sum;

  // A core has finished only once it has been seen leaving rdy after its start pulse.
  assign complete  = busy & seen_low & core_rdy;
  assign remaining = busy & ~complete;
  assign eligible  = ~busy & core_rdy;
  assign rdy       = (state == IDLE);

  assign end_sum = {1'b0, next_key} + {1'b0, CHUNK} - ONE;
  assign end_key = (end_sum > {1'b0, KEY_MAX}) ? KEY_MAX[KEY_W-1:0] : end_sum[KEY_W-1:0];

`ifdef CRACK_SCHED_ABORT_EN
  assign core_abort = (state == DRAIN) ? busy : '0;
`endif

  always_comb begin
    hit_any = 1'b0;
    hit_key = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (!hit_any && complete[i] && core_found[i]) begin
        hit_any = 1'b1;
        hit_key = core_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // Rotating priority: first scan cores at or above rr_ptr, then wrap to those below it.
  always_comb begin
    disp_any = 1'b0;
    disp_sel = '0;
    ptr_next = rr_ptr;
    for (int unsigned i = 0; i < NC; i++) begin
      if (!disp_any && eligible[i] && i >= 32'(rr_ptr)) begin
        disp_any    = 1'b1;
        disp_sel[i] = 1'b1;
        ptr_next    = (i == NC - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int unsigned i = 0; i < NC; i++) begin
      if (!disp_any && eligible[i] && i < 32'(rr_ptr)) begin
        disp_any    = 1'b1;
        disp_sel[i] = 1'b1;
        ptr_next    = (i == NC - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_next = state;
    disp_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        disp_ok = !hit_any && !next_key[KEY_W] && disp_any;
        if (hit_any)
          state_next = DRAIN;
        else if (next_key[KEY_W] && remaining == '0)
          state_next = IDLE;
      end
      DRAIN: begin
        if (remaining == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key            <= '0;
      key_valid      <= 1'b0;
      core_en        <= '0;
      core_start_key <= '0;
      core_end_key   <= '0;
      busy           <= '0;
      seen_low       <= '0;
      next_key       <= '0;
      rr_ptr         <= '0;
    end else begin
      core_en  <= '0;
      busy     <= remaining | (disp_ok ? disp_sel : '0);
      seen_low <= (seen_low | (busy & ~core_rdy)) & ~complete;
      if (disp_ok) begin
        core_en  <= disp_sel;
        next_key <= next_key + CHUNK;
        rr_ptr   <= ptr_next;
        for (int unsigned i = 0; i < NC; i++) begin
          if (disp_sel[i]) begin
            core_start_key[i*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
            core_end_key[i*KEY_W +: KEY_W]   <= end_key;
          end
        end
      end
      if (state == IDLE && en) begin
        key_valid <= 1'b0;
        next_key  <= '0;
        rr_ptr    <= '0;
      end
      if (state == RUN && hit_any) begin
        key       <= hit_key;
        key_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crack_scheduler.sv
// Bench for crack_scheduler: stub cores with programmable latency/hits, chunk plan derived arithmetically.
module tb_crack_scheduler;
  localparam int NC    = 2;
  localparam int CL    = 22;
  localparam int CHUNK = 1 << CL;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                rdy;
  logic [23:0]         key;
  logic                key_valid;
  logic [NC-1:0]       core_en;
  logic [NC-1:0]       core_rdy = '1;
  logic [NC*24-1:0]    core_start_key, core_end_key;
  logic [NC-1:0]       core_found = '0;
  logic [NC*24-1:0]    core_key = '0;
`ifdef CRACK_SCHED_ABORT_EN
  logic [NC-1:0]       core_abort;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  crack_scheduler #(.NUM_CORES(NC), .CHUNK_LOG2(CL), .KEY_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
    .core_en(core_en), .core_rdy(core_rdy), .core_start_key(core_start_key),
    .core_end_key(core_end_key), .core_found(core_found), .core_key(core_key)
`ifdef CRACK_SCHED_ABORT_EN
    , .core_abort(core_abort)
`endif
  );

  // Stub engines and dispatch log, all updated on the falling edge.
  int          lat_cfg[NC];
  int          cnt[NC];
  int          cur_disp[NC];
  int          cmpl_n[NC];
  bit          force_found[NC];
  logic [23:0] force_key[NC];
  int          hit_disp = -1;
  logic [23:0] hit_key;
  int          disp_n, multi_err, late_err;
  bit          hit_seen;
  time         last_cmpl_t, rdy_t;
  int          log_core[$];
  logic [23:0] log_start[$], log_end[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      core_rdy   = '1;
      core_found = '0;
      for (int i = 0; i < NC; i++) cnt[i] = 0;
    end else begin
      if (hit_seen && core_en != '0) late_err++;
      if ($countones(core_en) > 1) multi_err++;
      for (int i = 0; i < NC; i++) begin
        if (core_en[i]) begin
          log_core.push_back(i);
          log_start.push_back(core_start_key[i*24 +: 24]);
          log_end.push_back(core_end_key[i*24 +: 24]);
          cur_disp[i]   = disp_n;
          disp_n++;
          cnt[i]        = (lat_cfg[i] > 0) ? lat_cfg[i] : int'($urandom_range(2, 12));
          core_rdy[i]   = 1'b0;
          core_found[i] = 1'b0;
        end else if (!core_rdy[i]) begin
          if (cnt[i] <= 1) begin
            core_rdy[i] = 1'b1;
            cmpl_n[i]++;
            last_cmpl_t = $time;
            if (force_found[i]) begin
              core_found[i] = 1'b1;
              core_key[i*24 +: 24] = force_key[i];
            end else if (cur_disp[i] == hit_disp) begin
              core_found[i] = 1'b1;
              core_key[i*24 +: 24] = hit_key;
            end
            if (core_found[i]) hit_seen = 1'b1;
          end else begin
            cnt[i]--;
          end
        end
      end
    end
  end

  task automatic setup(input int l0, input int l1, input int hd);
    lat_cfg[0] = l0; lat_cfg[1] = l1; hit_disp = hd;
    force_found[0] = 1'b0; force_found[1] = 1'b0;
  endtask

  task automatic start_run();
    log_core.delete(); log_start.delete(); log_end.delete();
    disp_n = 0; multi_err = 0; late_err = 0; hit_seen = 1'b0;
    cmpl_n[0] = 0; cmpl_n[1] = 0;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic wait_rdy(input int max);
    bit got = 1'b0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk); #1;
      if (rdy) begin got = 1'b1; rdy_t = $time; break; end
    end
    total++;
    if (!got) $display("FAIL run_done: rdy=0 required 1 within %0d cycles", max);
    else passed++;
  endtask

  task automatic wait_cmpl(input int c, input int n, input int max);
    bit got = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk); #1;
      if (cmpl_n[c] >= n) begin got = 1'b1; break; end
    end
    total++;
    if (!got) $display("FAIL core%0d_done: completions=%0d required %0d", c, cmpl_n[c], n);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (rdy !== 1'b1) $display("FAIL rst_rdy: got %b expected 1", rdy); else passed++;
    total++; if (key_valid !== 1'b0) $display("FAIL rst_key_valid: got %b expected 0", key_valid); else passed++;
    total++; if (key !== 24'h0) $display("FAIL rst_key: got %h expected 000000", key); else passed++;
    total++; if (core_en !== 2'b00) $display("FAIL rst_core_en: got %b expected 00", core_en); else passed++;
    total++; if (core_start_key !== '0) $display("FAIL rst_start_key: got %h expected 0", core_start_key); else passed++;
    total++; if (core_end_key !== '0) $display("FAIL rst_end_key: got %h expected 0", core_end_key); else passed++;
`ifdef CRACK_SCHED_ABORT_EN
    total++; if (core_abort !== 2'b00) $display("FAIL rst_abort: got %b expected 00", core_abort); else passed++;
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    setup(10, 10, -1);
    start_run();
    #1;
    total++; if (rdy !== 1'b0) $display("FAIL basic_rdy_drop: got %b expected 0", rdy); else passed++;
    total++; if (core_en !== 2'b00) $display("FAIL basic_no_early_en: got %b expected 00", core_en); else passed++;
    @(negedge clk); #1;
    total++; if (core_en !== 2'b01) $display("FAIL basic_first_en: got %b expected 01", core_en); else passed++;
    wait_rdy(300);
    total++; if (log_core.size() !== 4) $display("FAIL basic_count: got %0d expected 4", log_core.size()); else passed++;
    for (int k = 0; k < 4 && k < log_core.size(); k++) begin
      total++; if (log_core[k] !== k % 2) $display("FAIL basic_core%0d: got %0d expected %0d", k, log_core[k], k % 2); else passed++;
      total++; if (log_start[k] !== 24'(k * CHUNK)) $display("FAIL basic_start%0d: got %h expected %h", k, log_start[k], 24'(k * CHUNK)); else passed++;
      total++; if (log_end[k] !== 24'((k + 1) * CHUNK - 1)) $display("FAIL basic_end%0d: got %h expected %h", k, log_end[k], 24'((k + 1) * CHUNK - 1)); else passed++;
    end
    total++; if (key_valid !== 1'b0) $display("FAIL basic_key_valid: got %b expected 0", key_valid); else passed++;
    total++; if (rdy_t - last_cmpl_t !== 11) $display("FAIL basic_rdy_latency: got %0t expected 11", rdy_t - last_cmpl_t); else passed++;
    total++; if (multi_err !== 0) $display("FAIL basic_one_dispatch: got %0d multi-enable cycles expected 0", multi_err); else passed++;
  endtask

  task automatic test_ignored_start();
    setup(10, 10, -1);
    start_run();
    repeat (4) @(negedge clk);
    en = 1'b1; @(negedge clk); en = 1'b0;
    repeat (7) @(negedge clk);
    en = 1'b1; @(negedge clk); en = 1'b0;
    wait_rdy(300);
    total++; if (log_core.size() !== 4) $display("FAIL ign_count: got %0d expected 4", log_core.size()); else passed++;
    for (int k = 0; k < 4 && k < log_core.size(); k++) begin
      total++; if (log_core[k] !== k % 2) $display("FAIL ign_core%0d: got %0d expected %0d", k, log_core[k], k % 2); else passed++;
      total++; if (log_start[k] !== 24'(k * CHUNK)) $display("FAIL ign_start%0d: got %h expected %h", k, log_start[k], 24'(k * CHUNK)); else passed++;
    end
  endtask

  task automatic test_hit_drain();
    setup(30, 5, 1);
    hit_key = 24'h5A5A5A;
    force_found[0] = 1'b1; force_key[0] = 24'h123456;
    start_run();
    wait_cmpl(1, 1, 100);
    repeat (3) @(negedge clk);
    #1;
    total++; if (rdy !== 1'b0) $display("FAIL drain_rdy_held: got %b expected 0", rdy); else passed++;
    total++; if (key !== 24'h5A5A5A) $display("FAIL drain_key: got %h expected 5a5a5a", key); else passed++;
    total++; if (key_valid !== 1'b1) $display("FAIL drain_key_valid: got %b expected 1", key_valid); else passed++;
    wait_rdy(200);
    total++; if (cmpl_n[0] !== 1) $display("FAIL drain_c0_done: got %0d expected 1", cmpl_n[0]); else passed++;
    total++; if (key !== 24'h5A5A5A) $display("FAIL drain_key_kept: got %h expected 5a5a5a", key); else passed++;
    total++; if (rdy_t - last_cmpl_t !== 11) $display("FAIL drain_rdy_latency: got %0t expected 11", rdy_t - last_cmpl_t); else passed++;
    total++; if (late_err !== 0) $display("FAIL drain_no_dispatch: got %0d late enables expected 0", late_err); else passed++;
    total++; if (log_core.size() !== 2) $display("FAIL drain_count: got %0d expected 2", log_core.size()); else passed++;
    force_found[0] = 1'b0;
  endtask

  task automatic test_simultaneous();
    setup(10, 9, -1);
    force_found[0] = 1'b1; force_key[0] = 24'h111111;
    force_found[1] = 1'b1; force_key[1] = 24'h222222;
    start_run();
    wait_rdy(200);
    total++; if (key !== 24'h111111) $display("FAIL simul_key: got %h expected 111111", key); else passed++;
    total++; if (key_valid !== 1'b1) $display("FAIL simul_key_valid: got %b expected 1", key_valid); else passed++;
    total++; if (log_core.size() !== 2) $display("FAIL simul_count: got %0d expected 2", log_core.size()); else passed++;
    force_found[0] = 1'b0; force_found[1] = 1'b0;
  endtask

  task automatic test_reset_midrun();
    bit got = 1'b0;
    setup(10, 10, -1);
    start_run();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (disp_n >= 2) begin got = 1'b1; break; end
    end
    total++; if (!got) $display("FAIL mid_two_dispatches: got %0d expected 2", disp_n); else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (rdy !== 1'b1) $display("FAIL mid_rst_rdy: got %b expected 1", rdy); else passed++;
    total++; if (core_en !== 2'b00) $display("FAIL mid_rst_core_en: got %b expected 00", core_en); else passed++;
    total++; if (key_valid !== 1'b0) $display("FAIL mid_rst_key_valid: got %b expected 0", key_valid); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_run();
    wait_rdy(300);
    total++; if (log_core.size() !== 4) $display("FAIL mid_restart_count: got %0d expected 4", log_core.size()); else passed++;
    if (log_core.size() > 0) begin
      total++; if (log_start[0] !== 24'h0) $display("FAIL mid_restart_start: got %h expected 000000", log_start[0]); else passed++;
      total++; if (log_core[0] !== 0) $display("FAIL mid_restart_core: got %0d expected 0", log_core[0]); else passed++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int h;
      h = int'($urandom_range(0, 4));
      setup(0, 0, (h == 4) ? -1 : h);
      if (h < 4) hit_key = 24'(h * CHUNK + int'($urandom_range(0, CHUNK - 1)));
      start_run();
      wait_rdy(400);
      for (int k = 0; k < log_core.size(); k++) begin
        total++; if (log_start[k] !== 24'(k * CHUNK)) $display("FAIL rnd%0d_start%0d: got %h expected %h", r, k, log_start[k], 24'(k * CHUNK)); else passed++;
        total++; if (log_end[k] !== 24'((k + 1) * CHUNK - 1)) $display("FAIL rnd%0d_end%0d: got %h expected %h", r, k, log_end[k], 24'((k + 1) * CHUNK - 1)); else passed++;
      end
      if (h == 4) begin
        total++; if (log_core.size() !== 4) $display("FAIL rnd%0d_count: got %0d expected 4", r, log_core.size()); else passed++;
        total++; if (key_valid !== 1'b0) $display("FAIL rnd%0d_key_valid: got %b expected 0", r, key_valid); else passed++;
      end else begin
        total++; if (log_core.size() < h + 1) $display("FAIL rnd%0d_count: got %0d expected at least %0d", r, log_core.size(), h + 1); else passed++;
        total++; if (key_valid !== 1'b1) $display("FAIL rnd%0d_key_valid: got %b expected 1", r, key_valid); else passed++;
        total++; if (key !== hit_key) $display("FAIL rnd%0d_key: got %h expected %h", r, key, hit_key); else passed++;
        total++; if (late_err !== 0) $display("FAIL rnd%0d_no_dispatch_after_hit: got %0d expected 0", r, late_err); else passed++;
      end
      total++; if (multi_err !== 0) $display("FAIL rnd%0d_one_dispatch: got %0d expected 0", r, multi_err); else passed++;
    end
    hit_disp = -1;
  endtask

`ifdef CRACK_SCHED_ABORT_EN
  task automatic test_abort();
    setup(5, 40, 0);
    hit_key = 24'h0ABCDE;
    start_run();
    wait_cmpl(0, 1, 100);
    repeat (2) @(negedge clk);
    #1;
    total++; if (core_abort !== 2'b10) $display("FAIL abort_drain: got %b expected 10", core_abort); else passed++;
    total++; if (rdy !== 1'b0) $display("FAIL abort_rdy_held: got %b expected 0", rdy); else passed++;
    wait_cmpl(1, 1, 100);
    total++; if (core_abort !== 2'b10) $display("FAIL abort_held: got %b expected 10", core_abort); else passed++;
    @(negedge clk); #1;
    total++; if (core_abort !== 2'b00) $display("FAIL abort_clear: got %b expected 00", core_abort); else passed++;
    total++; if (rdy !== 1'b1) $display("FAIL abort_rdy: got %b expected 1", rdy); else passed++;
    total++; if (key !== 24'h0ABCDE) $display("FAIL abort_key: got %h expected 0abcde", key); else passed++;
    hit_disp = -1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignored_start();
    test_hit_drain();
    test_simultaneous();
    test_reset_midrun();
`ifdef CRACK_SCHED_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
